fifo_word_packer: RTL
=====================

Name: fifo_word_packer

Overview:
- Downstream consumer of the team's nibble FIFO, on the FIFO's read side.
- Pops DATA_WIDTH-bit items whenever the FIFO is non-empty and packs PACK consecutive items into one wide word.
- Presents each word on a valid/ready output port to the next stage.
- FLUSH emits a partially filled word, so tail data never sits stranded in the packer.

Parameters:
- DATA_WIDTH, 4, width of one FIFO item.
- PACK, 4, items per output word; must be 2 or more.
- CNT_BITS, clog2(PACK+1) = 3, localparam, width of item counters and OUT_COUNT.

Ports:
- CLOCK  in  1  single clock; the FIFO read side runs on the same clock.
- RESET  in  1  asynchronous, active-low reset.
- FIFO_EMPTY  in  1  FIFO empty flag.
- FIFO_RD_EN  out  1  FIFO read strobe.
- FIFO_RD_DATA  in  DATA_WIDTH  FIFO registered read data; valid the cycle after FIFO_RD_EN.
- FLUSH  in  1  request to emit the current partial word.
- OUT_DATA  out  DATA_WIDTH*PACK  packed word; the first item popped sits in the LSBs.
- OUT_COUNT  out  CNT_BITS  number of valid items in OUT_DATA, from 1 to PACK.
- OUT_VALID  out  1  output word valid.
- OUT_READY  in  1  downstream accepts the word.
- BUSY  out  1  the packer holds or expects data.

Behaviour:
- Reset (RESET=0, asynchronous): state=FILL, issued=0, captured=0, rd_pend=0. OUT_DATA=0, OUT_COUNT=0, OUT_VALID=0, BUSY=0. FIFO_RD_EN is forced to 0 while RESET=0.
- Reset mid-operation: the pending read and the partial word are discarded. No word is emitted.
- States: FILL (collecting items) and HOLD (word presented).
- FIFO_RD_EN is combinational: state==FILL && !FIFO_EMPTY && issued<PACK && !flush_lat.
  - Back-to-back reads are allowed, one per cycle.
  - Each strobe increments issued.
  - rd_pend <= FIFO_RD_EN every cycle.
- Capture: on the edge where rd_pend==1, FIFO_RD_DATA is written to slot [captured*DATA_WIDTH +: DATA_WIDTH], and captured increments.
- flush_lat: set when FLUSH=1 in FILL with issued>0 or rd_pend=1. It stays set until the transition to HOLD.
  - FLUSH with issued==0 and rd_pend==0 is ignored.
  - FLUSH in HOLD is ignored.
- FILL -> HOLD happens on the capture edge where captured becomes PACK, or where flush_lat=1 and no further read is outstanding.
  - If flush_lat is set with rd_pend=0 and captured>0, the transition happens at the next edge.
  - On entry to HOLD: OUT_VALID=1, OUT_COUNT=captured, unused upper slots are 0.
- HOLD: no FIFO reads are issued. OUT_DATA and OUT_COUNT stay stable while OUT_VALID=1 && OUT_READY=0.
  - On OUT_VALID && OUT_READY: OUT_VALID=0, OUT_DATA cleared, issued=captured=0, flush_lat=0, state=FILL.
  - New reads may start in the cycle after the handshake.
- Latency: with a non-empty FIFO, first FIFO_RD_EN in cycle 0 gives OUT_VALID=1 in cycle PACK+1. Steady-state throughput is one word per PACK+2 cycles with OUT_READY tied high.
- FIFO_EMPTY rising mid-word: reads pause and the collected items are kept. Reads resume when FIFO_EMPTY falls.
- Counters never exceed PACK. OUT_READY while OUT_VALID=0 has no effect.
- BUSY = (state==HOLD) || issued!=0 || rd_pend.

Decomposition:
- Shared package fifo_pkg holds:
  - FILL/HOLD state encodings as localparams.
  - Default DATA_WIDTH.
  - Default PACK.
  - clog2 constant function.
- No sub-module. The packer is a single module.
- The bench instantiates the existing FIFO as the upstream source.

Test Plan:
- Preload FIFO with 1,2,3,4, OUT_READY=1 -> FIFO_RD_EN high cycles 0-3; OUT_VALID in cycle 5 with OUT_DATA=16'h4321, OUT_COUNT=4; BUSY=0 after the handshake.
- Preload 8 items 1-8, OUT_READY=0 for 10 cycles after first OUT_VALID -> OUT_DATA holds 16'h4321 and no FIFO reads occur; after OUT_READY=1, second word is 16'h8765.
- Write A,B then stop, pulse FLUSH -> OUT_VALID with OUT_DATA=16'h00BA, OUT_COUNT=2.
- FLUSH while FIFO empty and packer idle -> OUT_VALID stays 0 and BUSY stays 0 for 20 cycles.
- Items 1,2, then FIFO empty 5 cycles, then 3,4 -> single word 16'h4321 with no gap artefacts.
- Assert RESET=0 after 2 items captured, release, then supply 5,6,7,8 -> first output 16'h8765; items 1,2 are never emitted.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the nibble FIFO family: packer state encodings,
// default geometry and a constant clog2 used to size counters.
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 4;
  localparam int DEFAULT_PACK       = 4;

  localparam logic STATE_FILL = 1'b0;
  localparam logic STATE_HOLD = 1'b1;

  typedef enum logic {
    FILL = STATE_FILL,
    HOLD = STATE_HOLD
  } pack_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << result) < value) result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_word_packer_if.sv
// Bundle of the FIFO read side and the packed-word output handshake.
// The master modport is the packer; the slave modport is its environment.
interface fifo_word_packer_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int PACK       = DEFAULT_PACK
);

  localparam int CNT_BITS = clog2(PACK + 1);

  logic                       fifo_empty;
  logic                       fifo_rd_en;
  logic [DATA_WIDTH-1:0]      fifo_rd_data;
  logic                       flush;
  logic [DATA_WIDTH*PACK-1:0] out_data;
  logic [CNT_BITS-1:0]        out_count;
  logic                       out_valid;
  logic                       out_ready;
  logic                       busy;

  modport master (
    input  fifo_empty, fifo_rd_data, flush, out_ready,
    output fifo_rd_en, out_data, out_count, out_valid, busy
  );

  modport slave (
    output fifo_empty, fifo_rd_data, flush, out_ready,
    input  fifo_rd_en, out_data, out_count, out_valid, busy
  );

endinterface

// File: rtl/fifo_word_packer.sv
// Pops items from the nibble FIFO and packs PACK of them (first item in the
// LSBs) into one word on a valid/ready port; FLUSH emits a partial word.
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int PACK       = DEFAULT_PACK
) (
  input logic               clk,
  input logic               rst_n,
  fifo_word_packer_if.master bus
);

  localparam int                  CNT_BITS  = clog2(PACK + 1);
  localparam int                  WORD_BITS = DATA_WIDTH * PACK;
  localparam logic [CNT_BITS-1:0] PACK_CNT  = CNT_BITS'(PACK);

  pack_state_t          state, state_next;
  logic [CNT_BITS-1:0]  issued, issued_next;
  logic [CNT_BITS-1:0]  captured, captured_next;
  logic                 rd_pend;
  logic                 flush_lat, flush_lat_next;
  logic [WORD_BITS-1:0] word_q, word_next;
  logic                 rd_en;

  // Reads stop once a full word is in flight or a flush is draining the last read.
  assign rd_en = rst_n && (state == FILL) && !bus.fifo_empty &&
                 (issued < PACK_CNT) && !flush_lat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      issued    <= '0;
      captured  <= '0;
      rd_pend   <= 1'b0;
      flush_lat <= 1'b0;
      word_q    <= '0;
    end else begin
      state     <= state_next;
      issued    <= issued_next;
      captured  <= captured_next;
      rd_pend   <= rd_en;
      flush_lat <= flush_lat_next;
      word_q    <= word_next;
    end
  end

  // At most one read is outstanding, so a latched flush can close the word as
  // soon as the final pending item lands in its slot.
  always_comb begin
    state_next     = state;
    issued_next    = issued;
    captured_next  = captured;
    flush_lat_next = flush_lat;
    word_next      = word_q;
    case (state)
      FILL: begin
        if (rd_en) issued_next = issued + 1'b1;
        if (rd_pend) begin
          word_next[captured*DATA_WIDTH +: DATA_WIDTH] = bus.fifo_rd_data;
          captured_next = captured + 1'b1;
        end
        if (bus.flush && ((issued != '0) || rd_pend)) flush_lat_next = 1'b1;
        if ((captured_next == PACK_CNT) || (flush_lat && (captured_next != '0))) begin
          state_next     = HOLD;
          flush_lat_next = 1'b0;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_next    = FILL;
          issued_next   = '0;
          captured_next = '0;
          word_next     = '0;
        end
      end
      default: state_next = FILL;
    endcase
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.out_valid  = (state == HOLD);
  assign bus.out_data   = (state == HOLD) ? word_q : '0;
  assign bus.out_count  = (state == HOLD) ? captured : '0;
  assign bus.busy       = (state == HOLD) || (issued != '0) || rd_pend;

endmodule
